chacha_quarter_round_inv: RTL



---
 rtl/chacha_quarter_round_inv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/chacha_quarter_round_inv.sv
// chacha_quarter_round_inv
//   Iterative inverse of the ChaCha quarter round. An output tuple (a,b,c,d) is
//   loaded, the four quarter-round steps are undone in reverse order over
//   4/STEPS_PER_CYCLE cycles, and the recovered input tuple is presented on a
//   valid/ready stream.
//
// Ports
//   aclk, areset (async, active-high), srst (sync, active-high clear)
//   i_valid / i_ready / i_a..i_d : input tuple stream (quarter-round outputs)
//   o_valid / o_ready / o_a..o_d : recovered tuple stream (quarter-round inputs)

module chacha_quarter_round_inv #(
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        srst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);

    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4))
    begin : g_bad_steps
        $error("STEPS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [2:0]   k_q, k_d;      // next inverse step to apply (0..4)
    logic [127:0] w_q, w_d;      // working words {a,b,c,d}
    logic [127:0] res_q, res_d;  // held result; stable outside RUN
    logic [127:0] w_run;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One inverse step; each operation consumes the previous one's result.
    function automatic logic [127:0] inv_step(input logic [1:0] k, input logic [127:0] w);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = w;
        case (k)
            2'd0: begin b = rotr(b, 7);  b = b ^ c; c = c - d; end
            2'd1: begin d = rotr(d, 8);  d = d ^ a; a = a - b; end
            2'd2: begin b = rotr(b, 12); b = b ^ c; c = c - d; end
            default: begin d = rotr(d, 16); d = d ^ a; a = a - b; end
        endcase
        return {a, b, c, d};
    endfunction

    always_comb begin
        w_run = w_q;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            w_run = inv_step(k_q[1:0] + i[1:0], w_run);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        res_d   = res_q;
        i_ready = 1'b0;
        o_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    w_d     = {i_a, i_b, i_c, i_d};
                    k_d     = 3'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                w_d = w_run;
                k_d = k_q + 3'(STEPS_PER_CYCLE);
                if (k_d == 3'd4) begin
                    res_d   = w_run;
                    state_d = StDone;
                end
            end
            StDone: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
            w_q     <= '0;
            res_q   <= '0;
        end else if (srst) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
            w_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            res_q   <= res_d;
        end
    end

    assign o_a = res_q[127:96];
    assign o_b = res_q[95:64];
    assign o_c = res_q[63:32];
    assign o_d = res_q[31:0];

endmodule
